rv_lsu: RTL and testbench

RV_LSU -- requirements
Module: rv_lsu

---
 rtl/rv_lsu.sv | 152 +++++++++++++++
 tb/tb_rv_lsu.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rv_lsu.sv
// RV32 load/store unit: one access at a time over a word-wide memory bus, with a BUSY timeout.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse misalign.
module rv_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_f3;
  logic        r_we, r_bus_err;
  logic [CW-1:0] r_cnt;

  logic [31:0] w_eff_addr, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_is_half, w_is_word;

  assign w_is_half = (funct3[1:0] == 2'b01);
  assign w_is_word = funct3[1];

  // Without the trap, misaligned low bits are simply dropped before the access.
  always_comb begin
    w_eff_addr = addr;
    if (w_is_word)      w_eff_addr[1:0] = 2'b00;
    else if (w_is_half) w_eff_addr[0]   = 1'b0;
  end

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_f3[1:0])
      2'b00:   w_load = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_f3[2] & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    case (r_f3[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << r_addr[1:0];
        mem_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        mem_be    = 4'b0011 << r_addr[1:0];
        mem_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = r_wdata;
      end
    endcase
  end

  assign mem_req  = (r_state == S_BUSY);
  assign mem_we   = r_we;
  assign mem_addr = {r_addr[31:2], 2'b00};
  assign stall    = req_valid & (r_state != S_DONE);
  assign rdata    = r_rdata;
  assign bus_err  = r_bus_err;

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_mis;
  assign w_mis    = (w_is_word & (addr[1:0] != 2'b00)) | (w_is_half & addr[0]);
  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!srst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f3      <= '0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr  <= w_eff_addr;
          r_wdata <= wdata;
          r_f3    <= funct3;
          r_we    <= req_we;
          r_cnt   <= '0;
`ifdef MISALIGN_TRAP_EN
          if (w_mis) begin
            r_state    <= S_DONE;
            r_misalign <= 1'b1;
          end else begin
            r_state <= S_BUSY;
          end
`else
          r_state <= S_BUSY;
`endif
        end
        S_BUSY: begin
          // Ack wins over a timeout landing in the same cycle.
          if (mem_ack) begin
            r_state <= S_DONE;
            if (!r_we) r_rdata <= w_load;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_state   <= S_DONE;
            r_bus_err <= 1'b1;
            if (!r_we) r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu: driver queues expected bus beats and results, monitors compare.
module tb_rv_lsu;
  logic        clk = 1'b0;
  logic        srst, req_valid, req_we, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        stall, misalign, bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;

  rv_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .srst(srst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [3:0] be; logic we; logic [31:0] wd; } bus_t;
  typedef struct packed { logic [31:0] rd; logic berr; logic mis; } res_t;

  bus_t bq[$];
  res_t rq[$];
  int   total = 0, passed = 0;
  logic prev_req = 1'b0;
  bus_t cap;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Bus and completion monitors
  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (bq.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
      else begin
        bus_t e;
        e = bq.pop_front();
        chk("mem_addr", mem_addr, e.a);
        chk("mem_be", {28'd0, mem_be}, {28'd0, e.be});
        chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
        chk("mem_wdata", mem_wdata, e.wd);
      end
      cap = '{a: mem_addr, be: mem_be, we: mem_we, wd: mem_wdata};
    end else if (mem_req && prev_req) begin
      chk("bus_stable", {31'd0, cap == '{a: mem_addr, be: mem_be, we: mem_we, wd: mem_wdata}}, 32'd1);
    end
    prev_req = mem_req;
    if (srst && req_valid && !stall) begin
      if (rq.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
      else begin
        res_t r;
        r = rq.pop_front();
        chk("rdata", rdata, r.rd);
        chk("bus_err", {31'd0, bus_err}, {31'd0, r.berr});
        chk("misalign", {31'd0, misalign}, {31'd0, r.mis});
      end
    end
  end

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, mrd,
                        input int ack_at, input int exp_busy, input int exp_stall,
                        input logic bus_on, input bus_t eb, input res_t er);
    int busy = 0, st = 0;
    logic done = 1'b0;
    if (bus_on) bq.push_back(eb);
    rq.push_back(er);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd; mem_rdata = mrd;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (stall) st++;
      if (mem_req) begin
        busy++;
        mem_ack = (busy == ack_at + 1);
      end else mem_ack = 1'b0;
      if (!stall) done = 1'b1;
      else begin @(posedge clk); #2; end
    end
    if (!done) chk("done_bound", 32'd0, 32'd1);
    chk("busy_cycles", busy, exp_busy);
    chk("stall_cycles", st, exp_stall);
    mem_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    chk("no_restart_from_done", {31'd0, mem_req}, 32'd0);
    chk("err_pulse_end", {30'd0, bus_err, misalign}, 32'd0);
  endtask

  logic [31:0] last_rd;

  initial begin
    int busy;
    srst = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b010;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {30'd0, bus_err, misalign}, 32'd0);
    srst = 1'b1;
    @(posedge clk); #1;

    access(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 1, 2, 1, '{32'h100, 4'b1111, 1'b0, 32'h0},
           '{32'hDEADBEEF, 1'b0, 1'b0});
    access(0, 3'b000, 32'h103, 0, 32'h80FFFFFF, 0, 1, 2, 1, '{32'h100, 4'b1000, 1'b0, 32'h0},
           '{32'hFFFFFF80, 1'b0, 1'b0});
    access(0, 3'b100, 32'h103, 0, 32'h80FFFFFF, 0, 1, 2, 1, '{32'h100, 4'b1000, 1'b0, 32'h0},
           '{32'h00000080, 1'b0, 1'b0});
    access(0, 3'b001, 32'h106, 0, 32'h80011234, 0, 1, 2, 1, '{32'h104, 4'b1100, 1'b0, 32'h0},
           '{32'hFFFF8001, 1'b0, 1'b0});
`ifdef MISALIGN_TRAP_EN
    access(0, 3'b010, 32'h102, 0, 32'h11223344, 0, 0, 1, 0, '{32'h0, 4'b0, 1'b0, 32'h0},
           '{32'hFFFF8001, 1'b0, 1'b1});
    last_rd = 32'hFFFF8001;
`else
    access(0, 3'b010, 32'h102, 0, 32'h11223344, 0, 1, 2, 1, '{32'h100, 4'b1111, 1'b0, 32'h0},
           '{32'h11223344, 1'b0, 1'b0});
    last_rd = 32'h11223344;
`endif
    access(1, 3'b001, 32'h22, 32'h1234ABCD, 32'h99999999, 1, 2, 3, 1,
           '{32'h20, 4'b1100, 1'b1, 32'hABCDABCD}, '{last_rd, 1'b0, 1'b0});
    access(1, 3'b000, 32'h101, 32'h000000A5, 32'h99999999, 0, 1, 2, 1,
           '{32'h100, 4'b0010, 1'b1, 32'hA5A5A5A5}, '{last_rd, 1'b0, 1'b0});

    // Reset during the second BUSY cycle, then a late ack
    bq.push_back('{32'h200, 4'b1111, 1'b0, 32'h0});
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h200; wdata = '0;
    mem_rdata = 32'h55555555;
    busy = 0;
    for (int c = 0; c < 10 && busy < 2; c++) begin
      @(posedge clk); #2;
      if (mem_req) busy++;
    end
    chk("rst_reached_busy2", busy, 2);
    srst = 1'b0;
    @(posedge clk); #1;
    srst = 1'b1; req_valid = 1'b0; mem_ack = 1'b1;
    #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    chk("late_ack_ignored_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_ignored_rdata", rdata, 32'd0);
    chk("late_ack_ignored_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;

    access(0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 15, 16, 17, 1,
           '{32'h300, 4'b1111, 1'b0, 32'h0}, '{32'hCAFEF00D, 1'b0, 1'b0});
    access(0, 3'b010, 32'h304, 0, 32'h12345678, -1, 16, 17, 1,
           '{32'h304, 4'b1111, 1'b0, 32'h0}, '{32'h00000000, 1'b1, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("bus_queue_empty", bq.size(), 0);
    chk("res_queue_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
